dec_stage: RTL and testbench
============================

DEC_STAGE -- requirements
Module: dec_stage

Interface
REQ-001 Parameter ADDR, default `AddrWidth: PC width in bits.
REQ-002 Parameter DATA, default `DataWidth: datapath width in bits.
REQ-003 Parameter INST, default `InstWidth: instruction width in bits.
REQ-004 Parameter WAY, default 2, legal range 1-4: instructions per fetch group.
REQ-005 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-006 Port reset_  input  1: asynchronous, active-low reset.
REQ-007 Port inst_pc  input  ADDR: PC of way 0.
REQ-008 Port inst  input  WAY*INST: fetch group; way i is in bits [i*INST +: INST].
REQ-009 Port inst_v  input  WAY: per-way valid mask.
REQ-010 Port inst_e_  input  1: active-low group enable.
REQ-011 Port flush  input  1: active-high pipeline flush.
REQ-012 Port is_full  input  1: downstream cannot accept this cycle.
REQ-013 Port stall  output  1: fetch must hold its group.
REQ-014 Port dec_e_out_  output  1: active-low output-group valid.
REQ-015 Port dec_v  output  WAY: per-way valid after masking.
REQ-016 Port dec_pc  output  WAY*ADDR: per-way PC.
REQ-017 Port rs1_out, rs2_out, rd_out  output  WAY x RegFile_t: per-way register fields.
REQ-018 Port imm_data_out  output  WAY x ImmData_t: per-way immediate.
REQ-019 Port unit_out  output  WAY x ExeUnit_t: per-way execution unit.
REQ-020 Port command_out  output  WAY x OpCommand_t: per-way operation command.
REQ-021 Port invalid_out  output  WAY: per-way illegal-instruction flag.

Function
REQ-022 Accept occurs when inst_e_==0, stall==0 and flush==0; any other combination captures nothing.
REQ-023 Accepted ways are decoded combinationally and registered; latency is 1 cycle from accept to dec_e_out_==0.
REQ-024 dec_pc[i] = inst_pc + 4*i, computed modulo 2^ADDR (wrap-around, no carry out).
REQ-025 Way i is valid only if inst_v[i]==1 and no lower valid way has invalid_out==1; an illegal way itself stays valid with invalid_out=1.
REQ-026 The buffer is a 3-state FSM: EMPTY, ONE (output register full), TWO (output and skid registers full).
REQ-027 EMPTY: accept -> ONE; otherwise stay in EMPTY.
REQ-028 ONE: accept with is_full=0 -> ONE with new data; accept with is_full=1 -> TWO (new group into skid); no accept with is_full=0 -> EMPTY; no accept with is_full=1 -> ONE, data held.
REQ-029 TWO: is_full=0 -> ONE (skid moves to output); is_full=1 -> TWO, both held stable.
REQ-030 stall is a registered output, 1 exactly when the state is TWO.
REQ-031 dec_e_out_ = 0 when the state is not EMPTY and dec_v != 0; otherwise 1.
REQ-032 flush has priority over everything: next state is EMPTY, both registers are dropped, and a same-cycle group is discarded.
REQ-033 Output fields are held unchanged while is_full==1.
REQ-034 A group whose inst_v==0 that is accepted produces dec_e_out_==1 and is not forwarded.

Reset
REQ-035 Asserting reset_ (low) asynchronously forces the state to EMPTY, stall=0, dec_e_out_=1, dec_v=0, invalid_out=0, and all data registers to 0.
REQ-036 Reset asserted during operation discards all buffered groups, and the first accept is possible on the first rising edge after reset_ deasserts.

Structure
REQ-037 DecStageState_t (EMPTY/ONE/TWO) and the per-way decoded-record struct belong in the shared decode.svh package.
REQ-038 RegFile_t, ImmData_t, ExeUnit_t and OpCommand_t are reused from the existing headers, not redefined.
REQ-039 WAY instances of the existing decoder sub-module are generated, one per way, with the skid buffer and FSM in dec_stage.

Verification
REQ-040 WAY=2, inst_pc=0xFFFFFFFC, two valid ADDI -> next cycle dec_e_out_=0, dec_v=2'b11, dec_pc={0x00000000,0xFFFFFFFC}.
REQ-041 Way0 illegal opcode 0x7F, way1 ADD -> dec_v=2'b01, invalid_out=2'b01.
REQ-042 Accept group A, then raise is_full and accept group B -> stall=1, A held; drop is_full -> A, then B emitted, stall=0.
REQ-043 State TWO with flush=1 and inst_e_=0 -> next cycle dec_e_out_=1, stall=0, and no group emitted.
REQ-044 reset_ pulled low mid-cycle while in state ONE -> outputs return to reset values immediately, without waiting for a clock edge.
REQ-045 inst_e_=0 with inst_v=2'b00 -> dec_e_out_ stays 1.

Source files
------------

// File: rtl/dec_stage_pkg.sv
// Shared decode-stage types.
// Holds the width defaults, the register/immediate/unit/command types,
// the decode-buffer state encoding and the per-way decoded record
// used by dec_stage and its decoder sub-module.
package dec_stage_pkg;

   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned InstWidth = 32;

   typedef logic [4:0]           RegFile_t;
   typedef logic [DataWidth-1:0] ImmData_t;

   typedef enum logic [1:0] {
      UNIT_NONE,
      UNIT_ALU,
      UNIT_MEM,
      UNIT_BR
   } ExeUnit_t;

   typedef enum logic [4:0] {
      CMD_NOP,
      CMD_ADD,
      CMD_SUB,
      CMD_SLL,
      CMD_SLT,
      CMD_SLTU,
      CMD_XOR,
      CMD_SRL,
      CMD_SRA,
      CMD_OR,
      CMD_AND,
      CMD_LUI,
      CMD_AUIPC,
      CMD_JAL,
      CMD_JALR,
      CMD_BRANCH,
      CMD_LOAD,
      CMD_STORE
   } OpCommand_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } DecStageState_t;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;

   typedef struct packed {
      RegFile_t   rs1;
      RegFile_t   rs2;
      RegFile_t   rd;
      ImmData_t   imm;
      ExeUnit_t   unit;
      OpCommand_t cmd;
      logic       invalid;
   } DecRec_t;

   // ALU command from funct3; bit 30 selects SUB only for register ops,
   // while SRA/SRAI use it in both forms.
   function automatic OpCommand_t alu_cmd(input logic [2:0] f3,
                                          input logic       alt,
                                          input logic       is_reg);
      OpCommand_t c;
      case (f3)
         3'd0:    c = (is_reg && alt) ? CMD_SUB : CMD_ADD;
         3'd1:    c = CMD_SLL;
         3'd2:    c = CMD_SLT;
         3'd3:    c = CMD_SLTU;
         3'd4:    c = CMD_XOR;
         3'd5:    c = alt ? CMD_SRA : CMD_SRL;
         3'd6:    c = CMD_OR;
         default: c = CMD_AND;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/dec_stage_decoder.sv
// Single-way instruction decoder.
// Ports:
//   i_inst  - one instruction word
//   o_rec   - decoded register fields, immediate, unit, command, illegal flag
module dec_stage_decoder
   import dec_stage_pkg::*;
#(
   parameter int unsigned INST = InstWidth
)(
   input  logic [INST-1:0] i_inst,
   output DecRec_t         o_rec
);

   logic [6:0] w_opc;
   logic [2:0] w_f3;

   assign w_opc = i_inst[6:0];
   assign w_f3  = i_inst[14:12];

   always_comb begin
      o_rec         = '0;
      o_rec.rs1     = i_inst[19:15];
      o_rec.rs2     = i_inst[24:20];
      o_rec.rd      = i_inst[11:7];
      o_rec.unit    = UNIT_NONE;
      o_rec.cmd     = CMD_NOP;
      o_rec.invalid = 1'b0;
      case (w_opc)
         OPC_OP: begin
            o_rec.unit = UNIT_ALU;
            o_rec.cmd  = alu_cmd(w_f3, i_inst[30], 1'b1);
         end
         OPC_OP_IMM: begin
            o_rec.rs2  = '0;
            o_rec.imm  = ImmData_t'($signed(i_inst[31:20]));
            o_rec.unit = UNIT_ALU;
            o_rec.cmd  = alu_cmd(w_f3, i_inst[30], 1'b0);
         end
         OPC_LOAD: begin
            o_rec.rs2  = '0;
            o_rec.imm  = ImmData_t'($signed(i_inst[31:20]));
            o_rec.unit = UNIT_MEM;
            o_rec.cmd  = CMD_LOAD;
         end
         OPC_STORE: begin
            o_rec.rd   = '0;
            o_rec.imm  = ImmData_t'($signed({i_inst[31:25], i_inst[11:7]}));
            o_rec.unit = UNIT_MEM;
            o_rec.cmd  = CMD_STORE;
         end
         OPC_BRANCH: begin
            o_rec.rd   = '0;
            o_rec.imm  = ImmData_t'($signed({i_inst[31], i_inst[7], i_inst[30:25],
                                             i_inst[11:8], 1'b0}));
            o_rec.unit = UNIT_BR;
            o_rec.cmd  = CMD_BRANCH;
         end
         OPC_JAL: begin
            o_rec.rs1  = '0;
            o_rec.rs2  = '0;
            o_rec.imm  = ImmData_t'($signed({i_inst[31], i_inst[19:12], i_inst[20],
                                             i_inst[30:21], 1'b0}));
            o_rec.unit = UNIT_BR;
            o_rec.cmd  = CMD_JAL;
         end
         OPC_JALR: begin
            o_rec.rs2  = '0;
            o_rec.imm  = ImmData_t'($signed(i_inst[31:20]));
            o_rec.unit = UNIT_BR;
            o_rec.cmd  = CMD_JALR;
         end
         OPC_LUI, OPC_AUIPC: begin
            o_rec.rs1  = '0;
            o_rec.rs2  = '0;
            o_rec.imm  = ImmData_t'($signed({i_inst[31:12], 12'h000}));
            o_rec.unit = UNIT_ALU;
            o_rec.cmd  = (w_opc == OPC_LUI) ? CMD_LUI : CMD_AUIPC;
         end
         default: begin
            o_rec.rs1     = '0;
            o_rec.rs2     = '0;
            o_rec.rd      = '0;
            o_rec.invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dec_stage.sv
// Decode stage: decodes a WAY-wide fetch group and holds it in a
// two-entry (output + skid) buffer so fetch only sees a registered stall.
// Ports:
//   clk, reset_          - clock, async active-low reset
//   inst_pc/inst/inst_v  - fetch group PC, instruction words, per-way valid
//   inst_e_              - active-low group enable
//   flush                - drops everything buffered and the same-cycle group
//   is_full              - downstream back-pressure
//   stall                - fetch must hold its group (buffer is full)
//   dec_e_out_/dec_v     - output group valid (active low) / per-way valid
//   dec_pc, *_out        - per-way PC and decoded fields
module dec_stage
   import dec_stage_pkg::*;
#(
   parameter int unsigned ADDR = AddrWidth,
   parameter int unsigned DATA = DataWidth,
   parameter int unsigned INST = InstWidth,
   parameter int unsigned WAY  = 2
)(
   input  logic                 clk,
   input  logic                 reset_,
   input  logic [ADDR-1:0]      inst_pc,
   input  logic [WAY*INST-1:0]  inst,
   input  logic [WAY-1:0]       inst_v,
   input  logic                 inst_e_,
   input  logic                 flush,
   input  logic                 is_full,
   output logic                 stall,
   output logic                 dec_e_out_,
   output logic [WAY-1:0]       dec_v,
   output logic [WAY*ADDR-1:0]  dec_pc,
   output RegFile_t             rs1_out      [WAY],
   output RegFile_t             rs2_out      [WAY],
   output RegFile_t             rd_out       [WAY],
   output ImmData_t             imm_data_out [WAY],
   output ExeUnit_t             unit_out     [WAY],
   output OpCommand_t           command_out  [WAY],
   output logic [WAY-1:0]       invalid_out
);

   DecRec_t             w_rec [WAY];
   logic [WAY-1:0]      w_v;
   logic [WAY*ADDR-1:0] w_pc;
   logic                w_accept;

   DecStageState_t      r_state;
   logic                r_stall;
   logic [WAY-1:0]      r_out_v;
   logic [WAY*ADDR-1:0] r_out_pc;
   DecRec_t             r_out_rec [WAY];
   logic [WAY-1:0]      r_skid_v;
   logic [WAY*ADDR-1:0] r_skid_pc;
   DecRec_t             r_skid_rec [WAY];

   for (genvar g = 0; g < WAY; g++) begin : g_way
      dec_stage_decoder #(.INST(INST)) u_dec (
         .i_inst (inst[g*INST +: INST]),
         .o_rec  (w_rec[g])
      );
      assign w_pc[g*ADDR +: ADDR] = inst_pc + ADDR'(4 * g);

      assign rs1_out[g]      = r_out_rec[g].rs1;
      assign rs2_out[g]      = r_out_rec[g].rs2;
      assign rd_out[g]       = r_out_rec[g].rd;
      assign imm_data_out[g] = r_out_rec[g].imm;
      assign unit_out[g]     = r_out_rec[g].unit;
      assign command_out[g]  = r_out_rec[g].cmd;
      assign invalid_out[g]  = r_out_rec[g].invalid;
   end

   // An illegal valid way kills every higher way but stays valid itself.
   always_comb begin
      logic blk;
      blk = 1'b0;
      w_v = '0;
      for (int unsigned i = 0; i < WAY; i++) begin
         w_v[i] = inst_v[i] & ~blk;
         if (inst_v[i] && w_rec[i].invalid) blk = 1'b1;
      end
   end

   assign w_accept = ~inst_e_ & ~r_stall & ~flush;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state   <= EMPTY;
         r_stall   <= 1'b0;
         r_out_v   <= '0;
         r_out_pc  <= '0;
         r_skid_v  <= '0;
         r_skid_pc <= '0;
         for (int unsigned i = 0; i < WAY; i++) begin
            r_out_rec[i]  <= '0;
            r_skid_rec[i] <= '0;
         end
      end else if (flush) begin
         r_state  <= EMPTY;
         r_stall  <= 1'b0;
         r_out_v  <= '0;
         r_skid_v <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_state   <= ONE;
                  r_out_v   <= w_v;
                  r_out_pc  <= w_pc;
                  r_out_rec <= w_rec;
               end
            end
            ONE: begin
               if (w_accept && !is_full) begin
                  r_out_v   <= w_v;
                  r_out_pc  <= w_pc;
                  r_out_rec <= w_rec;
               end else if (w_accept) begin
                  r_state    <= TWO;
                  r_stall    <= 1'b1;
                  r_skid_v   <= w_v;
                  r_skid_pc  <= w_pc;
                  r_skid_rec <= w_rec;
               end else if (!is_full) begin
                  r_state <= EMPTY;
                  r_out_v <= '0;
               end
            end
            TWO: begin
               if (!is_full) begin
                  r_state   <= ONE;
                  r_stall   <= 1'b0;
                  r_out_v   <= r_skid_v;
                  r_out_pc  <= r_skid_pc;
                  r_out_rec <= r_skid_rec;
                  r_skid_v  <= '0;
               end
            end
            default: begin
               r_state <= EMPTY;
               r_stall <= 1'b0;
               r_out_v <= '0;
            end
         endcase
      end
   end

   assign stall      = r_stall;
   assign dec_v      = r_out_v;
   assign dec_pc     = r_out_pc;
   assign dec_e_out_ = ~((r_state != EMPTY) && (|r_out_v));

endmodule

// File: tb/tb_dec_stage.sv
module tb_dec_stage;
   import dec_stage_pkg::*;

   localparam logic [31:0] I_ADDI1 = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_ADDI2 = 32'hFFF0_8113; // addi x2,x1,-1
   localparam logic [31:0] I_ADD   = 32'h0020_81B3; // add  x3,x1,x2
   localparam logic [31:0] I_ILL   = 32'h0000_007F;

   logic        clk;
   logic        reset_;
   logic [31:0] inst_pc;
   logic [63:0] inst;
   logic [1:0]  inst_v;
   logic        inst_e_;
   logic        flush;
   logic        is_full;
   logic        stall;
   logic        dec_e_out_;
   logic [1:0]  dec_v;
   logic [63:0] dec_pc;
   RegFile_t    rs1_out [2];
   RegFile_t    rs2_out [2];
   RegFile_t    rd_out  [2];
   ImmData_t    imm_data_out [2];
   ExeUnit_t    unit_out [2];
   OpCommand_t  command_out [2];
   logic [1:0]  invalid_out;

   int n_checks = 0;
   int n_fail   = 0;

   dec_stage #(.ADDR(32), .DATA(32), .INST(32), .WAY(2)) dut (
      .clk          (clk),
      .reset_       (reset_),
      .inst_pc      (inst_pc),
      .inst         (inst),
      .inst_v       (inst_v),
      .inst_e_      (inst_e_),
      .flush        (flush),
      .is_full      (is_full),
      .stall        (stall),
      .dec_e_out_   (dec_e_out_),
      .dec_v        (dec_v),
      .dec_pc       (dec_pc),
      .rs1_out      (rs1_out),
      .rs2_out      (rs2_out),
      .rd_out       (rd_out),
      .imm_data_out (imm_data_out),
      .unit_out     (unit_out),
      .command_out  (command_out),
      .invalid_out  (invalid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] w1, input logic [31:0] w0,
                        input logic [1:0] v, input logic e_n);
      inst_pc = pc;
      inst    = {w1, w0};
      inst_v  = v;
      inst_e_ = e_n;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_  = 1'b0;
      flush   = 1'b0;
      is_full = 1'b0;
      drive(32'h0, 32'h0, 32'h0, 2'b00, 1'b1);
      #2;
      check_val("rst_stall", stall, 0);
      check_val("rst_e", dec_e_out_, 1);
      check_val("rst_v", dec_v, 0);
      check_val("rst_inv", invalid_out, 0);
      check_val("rst_pc", dec_pc, 0);
      @(posedge clk);
      #1;
      reset_ = 1'b1;

      // wrap-around PC, two valid ADDIs
      drive(32'hFFFF_FFFC, I_ADDI2, I_ADDI1, 2'b11, 1'b0);
      tick();
      check_val("wrap_e", dec_e_out_, 0);
      check_val("wrap_v", dec_v, 2'b11);
      check_val("wrap_pc", dec_pc, 64'h0000_0000_FFFF_FFFC);
      check_val("wrap_imm0", imm_data_out[0], 32'h5);
      check_val("wrap_imm1", imm_data_out[1], 32'hFFFF_FFFF);
      check_val("wrap_rd1", rd_out[1], 2);
      check_val("wrap_rs1_1", rs1_out[1], 1);
      check_val("wrap_cmd0", command_out[0], CMD_ADD);
      check_val("wrap_unit0", unit_out[0], UNIT_ALU);
      check_val("wrap_inv", invalid_out, 0);

      // illegal way 0 masks way 1 (back-to-back accept from ONE)
      drive(32'h0000_0040, I_ADD, I_ILL, 2'b11, 1'b0);
      tick();
      check_val("ill_v", dec_v, 2'b01);
      check_val("ill_inv", invalid_out, 2'b01);
      check_val("ill_e", dec_e_out_, 0);
      check_val("ill_pc", dec_pc, 64'h0000_0044_0000_0040);

      // accepted empty group
      drive(32'h0000_0080, I_ADD, I_ADD, 2'b00, 1'b0);
      tick();
      check_val("nov_e", dec_e_out_, 1);
      check_val("nov_v", dec_v, 0);
      drive(32'h0, 32'h0, 32'h0, 2'b00, 1'b1);
      tick();
      check_val("idle_e", dec_e_out_, 1);

      // skid: A, then B while downstream full
      drive(32'h0000_0100, I_ADD, I_ADDI1, 2'b01, 1'b0);
      tick();
      check_val("skA_e", dec_e_out_, 0);
      check_val("skA_pc", dec_pc[31:0], 32'h100);
      is_full = 1'b1;
      drive(32'h0000_0200, I_ADDI1, I_ADD, 2'b11, 1'b0);
      tick();
      check_val("skB_stall", stall, 1);
      check_val("skB_holdpc", dec_pc[31:0], 32'h100);
      check_val("skB_holdv", dec_v, 2'b01);
      check_val("skB_holdrd", rd_out[0], 1);
      inst_e_ = 1'b1;
      tick();
      check_val("skH_stall", stall, 1);
      check_val("skH_pc", dec_pc[31:0], 32'h100);
      is_full = 1'b0;
      tick();
      check_val("skD_stall", stall, 0);
      check_val("skD_pc", dec_pc, 64'h0000_0204_0000_0200);
      check_val("skD_v", dec_v, 2'b11);
      check_val("skD_e", dec_e_out_, 0);
      check_val("skD_rd0", rd_out[0], 3);
      tick();
      check_val("skE_e", dec_e_out_, 1);

      // flush while in TWO with a same-cycle group
      drive(32'h0000_0100, I_ADD, I_ADDI1, 2'b11, 1'b0);
      tick();
      is_full = 1'b1;
      drive(32'h0000_0200, I_ADD, I_ADD, 2'b11, 1'b0);
      tick();
      check_val("flTWO_stall", stall, 1);
      flush = 1'b1;
      drive(32'h0000_0300, I_ADD, I_ADD, 2'b11, 1'b0);
      tick();
      check_val("fl_e", dec_e_out_, 1);
      check_val("fl_stall", stall, 0);
      check_val("fl_v", dec_v, 0);
      flush   = 1'b0;
      is_full = 1'b0;
      inst_e_ = 1'b1;
      tick();
      check_val("flP_e", dec_e_out_, 1);

      // async reset mid-cycle in ONE
      drive(32'h0000_0500, I_ADD, I_ADD, 2'b11, 1'b0);
      tick();
      check_val("ar_pre_e", dec_e_out_, 0);
      inst_e_ = 1'b1;
      is_full = 1'b1;
      #2;
      reset_ = 1'b0;
      #1;
      check_val("ar_e", dec_e_out_, 1);
      check_val("ar_v", dec_v, 0);
      check_val("ar_stall", stall, 0);
      check_val("ar_pc", dec_pc, 0);
      #2;
      reset_  = 1'b1;
      is_full = 1'b0;
      drive(32'h0000_0400, I_ADDI1, I_ADDI2, 2'b11, 1'b0);
      tick();
      check_val("ar_first_e", dec_e_out_, 0);
      check_val("ar_first_pc", dec_pc[31:0], 32'h400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
